spec_free_list: RTL and testbench
=================================

Name: spec_free_list

Overview:
- Speculative physical-register free list for the rename stage.
- Circular buffer of PHY_REG_NUM free preg IDs: rename pops IDs from head, commit pushes released IDs at tail.
- On flush, head, tail and count are restored from the architectural free-list pointers, which are driven combinationally by the commit-side free list.
- Commit frees arrive here and at the architectural free list in the same cycle.

Parameters:
- PHY_REG_NUM, 64: number of physical registers, which is also the buffer depth. Power of two.
- RENAME_WIDTH, 4: allocation lanes per cycle.
- COMMIT_WIDTH, 4: free lanes per cycle. Bound to `COMMIT_WIDTH at instantiation.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous reset, active low
- flush_i  in  1  pipeline flush; restore from architectural pointers
- arch_head_i  in  $clog2(PHY_REG_NUM)  architectural head, next-state value
- arch_tail_i  in  $clog2(PHY_REG_NUM)  architectural tail, next-state value
- arch_cnt_i  in  $clog2(PHY_REG_NUM+1)  architectural free count, next-state value
- alloc_valid_i  in  RENAME_WIDTH  per-lane allocation request
- alloc_ready_o  out  1  list can satisfy any request this cycle
- alloc_preg_o  out  RENAME_WIDTH x $clog2(PHY_REG_NUM)  allocated preg per lane
- free_valid_i  in  COMMIT_WIDTH  per-lane release at commit
- free_preg_i  in  COMMIT_WIDTH x $clog2(PHY_REG_NUM)  released preg per lane
- free_cnt_o  out  $clog2(PHY_REG_NUM+1)  registered free count
- freelist_err_o  out  1  sticky integrity error (see Optional Feature)

Behaviour:
- State: list[PHY_REG_NUM] of preg IDs; head_q, tail_q (modulo PHY_REG_NUM, wrap naturally); cnt_q.
- Reset (async, rst_n low):
  - list[i] = i; head_q = 0; tail_q = 0; cnt_q = PHY_REG_NUM.
  - alloc_ready_o = 1; free_cnt_o = PHY_REG_NUM; freelist_err_o = 0.
- alloc_ready_o = (cnt_q >= RENAME_WIDTH) && !flush_i.
  - All-or-nothing: readiness never depends on how many lanes are valid.
- Allocation fires when alloc_ready_o and lane i is valid.
  - Output lane i: alloc_preg_o[i] = list[head_q + popcount(alloc_valid_i[i-1:0])] (combinational, zero latency, compacted order).
  - Lanes with valid low output don't-care.
  - With alloc_ready_o low, nothing is consumed.
- Frees always accepted, never back-pressured.
  - Lane j writes list[tail_q + popcount(free_valid_i[j-1:0])] = free_preg_i[j].
  - Written entries are visible to allocation from the next cycle; no same-cycle bypass.
- Next state, no flush:
  - head_q += alloc_cnt; tail_q += free_cnt; cnt_q += free_cnt - alloc_cnt.
  - alloc_cnt = popcount of fired alloc lanes; free_cnt = popcount(free_valid_i).
- Flush cycle:
  - No allocation: alloc_ready_o forced low.
  - Free writes into list still performed at tail_q-based addresses.
  - head_q <= arch_head_i; tail_q <= arch_tail_i; cnt_q <= arch_cnt_i.
  - The arch inputs already include this cycle's commits, so the in-flight frees are kept.
- Boundaries:
  - cnt_q == RENAME_WIDTH: ready; allocating all lanes drives cnt to 0.
  - cnt_q < RENAME_WIDTH: stalled until frees arrive.
  - Full list (cnt_q == PHY_REG_NUM) with frees: illegal. The simulation assertion fires; the counter is not saturated.
  - Pointer wrap: index arithmetic is truncated to $clog2(PHY_REG_NUM) bits.
  - Simultaneous alloc and free: both applied in the same cycle.
  - rst_n asserted mid-operation: immediate return to reset state; in-flight frees are lost by design.
- free_cnt_o = cnt_q.

Optional Feature:
- Macro: FREELIST_CHECK_EN.
- Enabled:
  - Shadow bitmap in_list[PHY_REG_NUM]: reset all 1.
    - Cleared on each fired allocation, set on each free.
    - On flush, rebuilt by marking all entries between arch_head_i and arch_tail_i (count arch_cnt_i) as free; this takes one cycle, during which alloc_ready_o is held low.
  - freelist_err_o sets, and stays set until reset, on either:
    - a free of a preg whose bit is already set (double free);
    - an allocation returning a preg whose bit is clear.
- Disabled: no bitmap; freelist_err_o tied 0; no extra flush cycle.

Test Plan:
- Reset, then alloc_valid_i=4'b1111 for 1 cycle -> alloc_preg_o={0,1,2,3}; next cycle free_cnt_o=60, head_q=4.
- alloc_valid_i=4'b1010 with head_q=4 -> lane1 gets 4, lane3 gets 5; free_cnt_o drops by 2.
- Allocate 16 cycles x 4 lanes -> cnt=0, alloc_ready_o=0. Free preg 7 and 9 -> cnt=2, still not ready. Free 2 more -> ready; next allocation returns {7,9,...} in free order.
- Wrap: head_q=62, tail_q=62, cnt=4, alloc 4 lanes -> reads list[62],[63],[0],[1]; head_q=2.
- Flush with arch_head_i=10, arch_tail_i=6, arch_cnt_i=60, plus a same-cycle free of preg 33 -> alloc_ready_o=0 that cycle; next cycle head_q=10, free_cnt_o=60; list[old tail_q]=33.
- With FREELIST_CHECK_EN, free preg 5 twice with no intervening allocation of 5 -> freelist_err_o=1 next cycle and stays 1 until rst_n.

Source files
------------

// File: rtl/spec_free_list.sv
// Speculative physical-register free list for rename: circular buffer of free preg IDs,
// popped at head by rename, pushed at tail by commit. Define FREELIST_CHECK_EN for the shadow-bitmap integrity check.
module spec_free_list #(
    parameter int PHY_REG_NUM  = 64,
    parameter int RENAME_WIDTH = 4,
    parameter int COMMIT_WIDTH = 4,
    localparam int IW = $clog2(PHY_REG_NUM),
    localparam int CW = $clog2(PHY_REG_NUM + 1)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush_i,
    input  logic [IW-1:0]                arch_head_i,
    input  logic [IW-1:0]                arch_tail_i,
    input  logic [CW-1:0]                arch_cnt_i,
    input  logic [RENAME_WIDTH-1:0]      alloc_valid_i,
    output logic                         alloc_ready_o,
    output logic [RENAME_WIDTH*IW-1:0]   alloc_preg_o,
    input  logic [COMMIT_WIDTH-1:0]      free_valid_i,
    input  logic [COMMIT_WIDTH*IW-1:0]   free_preg_i,
    output logic [CW-1:0]                free_cnt_o,
    output logic                         freelist_err_o
);

    logic [IW-1:0]           list_q [PHY_REG_NUM];
    logic [IW-1:0]           head_q;
    logic [IW-1:0]           tail_q;
    logic [CW-1:0]           cnt_q;
    logic [RENAME_WIDTH-1:0] alloc_fire;
    logic [CW-1:0]           alloc_cnt;
    logic [CW-1:0]           free_cnt;
    logic [IW-1:0]           free_idx [COMMIT_WIDTH];
    logic                    stall;

    // All-or-nothing readiness: independent of how many lanes request.
    assign alloc_ready_o = (cnt_q >= CW'(RENAME_WIDTH)) && !flush_i && !stall;
    assign free_cnt_o    = cnt_q;

    // Valid lanes read consecutive entries from head in lane order (compacted).
    always_comb begin : alloc_path
        logic [CW-1:0] off;
        // NOTE: every comb output gets a default before any branch, so no latch is inferred.
        off          = '0;
        alloc_preg_o = '0;
        for (int i = 0; i < RENAME_WIDTH; i++) begin
            alloc_preg_o[i*IW +: IW] = list_q[head_q + off[IW-1:0]];
            off = off + CW'(alloc_valid_i[i]);
        end
        alloc_fire = alloc_ready_o ? alloc_valid_i : '0;
        alloc_cnt  = alloc_ready_o ? off : '0;
    end

    always_comb begin : free_path
        logic [CW-1:0] off;
        off = '0;
        for (int j = 0; j < COMMIT_WIDTH; j++) begin
            free_idx[j] = tail_q + off[IW-1:0];
            off = off + CW'(free_valid_i[j]);
        end
        free_cnt = off;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the list is reset to the identity mapping, so this memory must sit in the reset branch.
            for (int i = 0; i < PHY_REG_NUM; i++) list_q[i] <= IW'(i);
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= CW'(PHY_REG_NUM);
        end else begin
            // NOTE: sequential state uses non-blocking assignments only.
            for (int j = 0; j < COMMIT_WIDTH; j++) begin
                if (free_valid_i[j]) list_q[free_idx[j]] <= free_preg_i[j*IW +: IW];
            end
            // Arch pointers already account for this cycle's commits, so the frees above survive a flush.
            if (flush_i) begin
                head_q <= arch_head_i;
                tail_q <= arch_tail_i;
                cnt_q  <= arch_cnt_i;
            end else begin
                head_q <= head_q + alloc_cnt[IW-1:0];
                tail_q <= tail_q + free_cnt[IW-1:0];
                cnt_q  <= cnt_q + free_cnt - alloc_cnt;
            end
        end
    end

`ifdef FREELIST_CHECK_EN
    logic [PHY_REG_NUM-1:0] in_list_q;
    logic [PHY_REG_NUM-1:0] in_list_d;
    logic                   rebuild_q;
    logic                   err_q;
    logic                   err_d;

    assign stall          = rebuild_q;
    assign freelist_err_o = err_q;

    // The cycle after a flush the bitmap is rebuilt from the restored head..head+cnt window.
    always_comb begin : check_path
        logic [IW-1:0] idx;
        logic [IW-1:0] p;
        idx       = '0;
        p         = '0;
        in_list_d = in_list_q;
        err_d     = err_q;
        if (rebuild_q) begin
            in_list_d = '0;
            for (int k = 0; k < PHY_REG_NUM; k++) begin
                idx = head_q + IW'(k);
                if (CW'(k) < cnt_q) in_list_d[list_q[idx]] = 1'b1;
            end
        end
        for (int i = 0; i < RENAME_WIDTH; i++) begin
            if (alloc_fire[i]) begin
                p = alloc_preg_o[i*IW +: IW];
                if (!in_list_d[p]) err_d = 1'b1;
                in_list_d[p] = 1'b0;
            end
        end
        for (int j = 0; j < COMMIT_WIDTH; j++) begin
            if (free_valid_i[j]) begin
                p = free_preg_i[j*IW +: IW];
                if (in_list_d[p]) err_d = 1'b1;
                in_list_d[p] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_list_q <= '1;
            rebuild_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            in_list_q <= in_list_d;
            rebuild_q <= flush_i;
            err_q     <= err_d;
        end
    end
`else
    assign stall          = 1'b0;
    assign freelist_err_o = 1'b0;
`endif

    // Commit can never release more registers than exist; the counter is deliberately not saturated.
    no_free_when_full: assert property (@(posedge clk) disable iff (!rst_n)
        !((cnt_q == CW'(PHY_REG_NUM)) && (|free_valid_i)))
        else $error("spec_free_list: release while list is full");

endmodule

// File: tb/tb_spec_free_list.sv
// Directed bench for spec_free_list: table-driven allocate/free vectors plus
// hand sequences for drain/stall, pointer wrap, flush restore, reset and double free.
module tb_spec_free_list;

    localparam int N  = 64;
    localparam int RW = 4;
    localparam int CM = 4;
    localparam int IW = 6;
    localparam int CW = 7;
`ifdef FREELIST_CHECK_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    typedef struct {
        logic [3:0]  av;
        logic [3:0]  fv;
        logic [23:0] fp;
        logic        fl;
        logic [5:0]  ah;
        logic [5:0]  at;
        logic [6:0]  ac;
        logic        rdy;
        logic [23:0] pg;
        logic [6:0]  cnt;
    } vec_t;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                flush_i = 1'b0;
    logic [IW-1:0]       arch_head_i = '0;
    logic [IW-1:0]       arch_tail_i = '0;
    logic [CW-1:0]       arch_cnt_i = '0;
    logic [RW-1:0]       alloc_valid_i = '0;
    logic                alloc_ready_o;
    logic [RW*IW-1:0]    alloc_preg_o;
    logic [CM-1:0]       free_valid_i = '0;
    logic [CM*IW-1:0]    free_preg_i = '0;
    logic [CW-1:0]       free_cnt_o;
    logic                freelist_err_o;

    int n_chk  = 0;
    int n_pass = 0;

    spec_free_list #(.PHY_REG_NUM(N), .RENAME_WIDTH(RW), .COMMIT_WIDTH(CM)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush_i        (flush_i),
        .arch_head_i    (arch_head_i),
        .arch_tail_i    (arch_tail_i),
        .arch_cnt_i     (arch_cnt_i),
        .alloc_valid_i  (alloc_valid_i),
        .alloc_ready_o  (alloc_ready_o),
        .alloc_preg_o   (alloc_preg_o),
        .free_valid_i   (free_valid_i),
        .free_preg_i    (free_preg_i),
        .free_cnt_o     (free_cnt_o),
        .freelist_err_o (freelist_err_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    function automatic logic [23:0] pk(input int a, input int b, input int c, input int d);
        return {6'(d), 6'(c), 6'(b), 6'(a)};
    endfunction

    function automatic vec_t mk(input logic [3:0] av, input logic [3:0] fv, input logic [23:0] fp,
                                input logic rdy, input logic [23:0] pg, input int cnt);
        vec_t v;
        v.av = av; v.fv = fv; v.fp = fp; v.fl = 1'b0; v.ah = '0; v.at = '0; v.ac = '0;
        v.rdy = rdy; v.pg = pg; v.cnt = 7'(cnt);
        return v;
    endfunction

    function automatic vec_t mk_flush(input logic [3:0] av, input logic [3:0] fv, input logic [23:0] fp,
                                      input int ah, input int at, input int ac);
        vec_t v;
        v = mk(av, fv, fp, 1'b0, '0, ac);
        v.fl = 1'b1; v.ah = 6'(ah); v.at = 6'(at); v.ac = 7'(ac);
        return v;
    endfunction

    // Called at posedge+1: drive, check comb outputs at negedge, check count after the edge.
    task automatic apply(input vec_t v, input string nm);
        alloc_valid_i = v.av;
        free_valid_i  = v.fv;
        free_preg_i   = v.fp;
        flush_i       = v.fl;
        arch_head_i   = v.ah;
        arch_tail_i   = v.at;
        arch_cnt_i    = v.ac;
        @(negedge clk);
        check({nm, " ready"}, 32'(alloc_ready_o), 32'(v.rdy));
        for (int i = 0; i < RW; i++) begin
            if (v.av[i] && v.rdy)
                check($sformatf("%s preg lane%0d", nm, i), 32'(alloc_preg_o[i*IW +: IW]), 32'(v.pg[i*IW +: IW]));
        end
        @(posedge clk);
        #1;
        check({nm, " free_cnt"}, 32'(free_cnt_o), 32'(v.cnt));
        alloc_valid_i = '0;
        free_valid_i  = '0;
        free_preg_i   = '0;
        flush_i       = 1'b0;
    endtask

    // Extra bitmap-rebuild cycle after a flush when the checker is built in.
    task automatic post_flush(input int cnt, input string nm);
`ifdef FREELIST_CHECK_EN
        apply(mk(4'b1111, 4'b0000, '0, 1'b0, '0, cnt), {nm, " rebuild"});
`else
        check({nm, " settled cnt"}, 32'(free_cnt_o), 32'(cnt));
`endif
    endtask

    task automatic do_reset(input string nm);
        rst_n = 1'b0;
        #1;
        check({nm, " rst ready"}, 32'(alloc_ready_o), 32'd1);
        check({nm, " rst free_cnt"}, 32'(free_cnt_o), 32'd64);
        check({nm, " rst err"}, 32'(freelist_err_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    vec_t tbl [5];

    initial begin
        tbl[0] = mk(4'b1111, 4'b0000, '0,               1'b1, pk(0, 1, 2, 3), 60);
        tbl[1] = mk(4'b1010, 4'b0000, '0,               1'b1, pk(0, 4, 0, 5), 58);
        tbl[2] = mk(4'b0001, 4'b0001, pk(2, 0, 0, 0),  1'b1, pk(6, 0, 0, 0), 58);
        tbl[3] = mk(4'b0110, 4'b1010, pk(0, 0, 0, 1),  1'b1, pk(0, 7, 8, 0), 58);
        tbl[4] = mk(4'b0000, 4'b0000, '0,               1'b1, '0,             58);

        repeat (2) @(posedge clk);
        #1;
        do_reset("init");
        for (int k = 0; k < 5; k++) apply(tbl[k], $sformatf("vec%0d", k));

        // Asynchronous reset mid-operation: in-flight frees are dropped.
        alloc_valid_i = 4'b1111;
        free_valid_i  = 4'b0001;
        free_preg_i   = pk(40, 0, 0, 0);
        #2;
        free_valid_i  = '0;
        alloc_valid_i = '0;
        do_reset("midop");

        // Drain all 64 entries; the last step starts at cnt == RENAME_WIDTH.
        for (int c = 0; c < 16; c++)
            apply(mk(4'b1111, 4'b0000, '0, 1'b1, pk(4*c, 4*c+1, 4*c+2, 4*c+3), 60 - 4*c), $sformatf("drain%0d", c));
        apply(mk(4'b1111, 4'b0000, '0,              1'b0, '0, 0), "empty stall");
        apply(mk(4'b1111, 4'b0101, pk(7, 0, 9, 0),  1'b0, '0, 2), "free 7,9");
        apply(mk(4'b0000, 4'b0011, pk(20, 21, 0, 0), 1'b0, '0, 4), "free 20,21");
        apply(mk(4'b1111, 4'b0000, '0,              1'b1, pk(7, 9, 20, 21), 0), "refill order");

        // Restore to head=62 and allocate across the pointer wrap.
        apply(mk_flush(4'b1111, 4'b0000, '0, 62, 62, 4), "flush wrap");
        post_flush(4, "flush wrap");
        apply(mk(4'b1111, 4'b0000, '0, 1'b1, pk(62, 63, 7, 9), 0), "wrap alloc");

        // Flush with a same-cycle free of 33 landing at old tail (62).
        apply(mk_flush(4'b1111, 4'b0001, pk(33, 0, 0, 0), 10, 6, 60), "flush restore");
        post_flush(60, "flush restore");
        apply(mk(4'b1111, 4'b0000, '0, 1'b1, pk(10, 11, 12, 13), 56), "head restored");
        apply(mk_flush(4'b0000, 4'b0000, '0, 62, 2, 4), "flush probe");
        post_flush(4, "flush probe");
        apply(mk(4'b1111, 4'b0000, '0, 1'b1, pk(33, 63, 7, 9), 0), "flush free kept");
        check("legal traffic err", 32'(freelist_err_o), 32'd0);

        // Double free of preg 5.
        do_reset("dfree");
        apply(mk(4'b1111, 4'b0000, '0, 1'b1, pk(0, 1, 2, 3), 60), "dfree a0");
        apply(mk(4'b1111, 4'b0000, '0, 1'b1, pk(4, 5, 6, 7), 56), "dfree a1");
        apply(mk(4'b0000, 4'b0001, pk(5, 0, 0, 0), 1'b1, '0, 57), "dfree f1");
        check("single free err", 32'(freelist_err_o), 32'd0);
        apply(mk(4'b0000, 4'b0001, pk(5, 0, 0, 0), 1'b1, '0, 58), "dfree f2");
        check("double free err", 32'(freelist_err_o), 32'(ERR_EXP));
        repeat (3) @(posedge clk);
        #1;
        check("double free sticky", 32'(freelist_err_o), 32'(ERR_EXP));
        do_reset("dfree clear");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
